e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Sits directly downstream of decode control and consumes its MDU-start indication, carried through the D/E pipeline register.
- Owns the HI/LO registers and executes mult, multu, div, divu, mthi, mtlo and mfhi/mflo.
- Presents a busy flag that the hazard logic uses to stall MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (≥1).
- DIV_CYCLES, 10, busy duration for div/divu (≥1).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high; clears all state.
- E_start  in  1  E-stage instruction is an MDU op (start bit from decode, piped to E).
- E_mdu_op  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 treated as none.
- E_A  in  32  forwarded rs value.
- E_B  in  32  forwarded rt value.
- E_req  in  1  exception/interrupt flush this cycle; E instruction is cancelled.
- E_busy  out  1  multi-cycle operation in progress.
- E_HI  out  32  architectural HI.
- E_LO  out  32  architectural LO.
- E_mdu_out  out  32  mfhi→HI, mflo→LO, otherwise 0 (combinational).

Behaviour:
- Reset (async, active-high): HI=0, LO=0, count=0, temp regs=0, E_busy=0. Reset wins over every other event, including mid-operation; a pending result is discarded.
- Accept condition: accept = E_start & ~E_req & ~E_busy, evaluated at the rising edge.
  - E_start with E_busy=1 is ignored (the stall logic prevents it).
  - E_req=1 suppresses every state change from the E instruction, including mthi/mtlo.
- mult/multu accepted:
  - The 64-bit product (signed or unsigned) is latched into temp_hi/temp_lo.
  - count loads MULT_CYCLES.
- div/divu accepted:
  - temp_lo = quotient, temp_hi = remainder, signed or unsigned.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Divisor 0: the operation still runs for DIV_CYCLES but HI/LO stay unchanged at commit (a no-commit flag is latched).
  - count loads DIV_CYCLES.
- Busy and commit:
  - E_busy = (count != 0), registered-state-derived, with no combinational path from inputs.
  - Each edge with count != 0 decrements count.
  - The edge where count goes 1→0 writes temp_hi/temp_lo into HI/LO, unless the no-commit flag is set.
  - Timing: start sampled at edge t0 → E_busy high for cycles t0+1 … t0+N → HI/LO valid from t0+N onward.
- mthi/mtlo accepted: HI (resp. LO) ← E_A at the same edge; one cycle; no busy.
- mfhi/mflo:
  - Read-only, combinational, with no state change.
  - Only valid when not busy; the hazard unit stalls them in D while (E_start | E_busy).
- E_req while E_busy=1: the in-flight operation belongs to an older, committed instruction, so it continues and commits normally.
- Hazard contract (outside this block): D stalls when the D instruction has its start bit set and (E_start | E_busy).

Decomposition:
- Shared package:
  - MDU op encodings (MDU_NONE … MDU_MTLO).
  - MULT_CYCLES and DIV_CYCLES default constants.
  - 4-bit op width.
- Decode-side encoding of the op lives next to the decode control logic and uses the same package constants.
- Sub-module:
  - Name: mdu_calc.
  - Purely combinational: op, A, B → {hi, lo, div_by_zero}.
  - Isolates the arithmetic from the counter/commit FSM in e_mdu.
- e_mdu itself holds count, temp regs, HI/LO and the accept/commit logic.

Test Plan:
- Signed mult:
  - Stimulus: mult, A=0xFFFFFFFF, B=0x00000002, E_start=1 at t0.
  - Response: E_busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi→E_mdu_out=0xFFFFFFFF.
- Unsigned mult:
  - Stimulus: multu, A=0xFFFFFFFF, B=0x00000002.
  - Response: after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed div, then divide-by-zero:
  - Stimulus: div, A=0xFFFFFFF9 (−7), B=2.
  - Response: 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then divu with B=0: busy for 10 cycles; HI/LO unchanged.
- Exception flush:
  - Stimulus: mtlo A=0x12345678 with E_req=1.
  - Response: LO unchanged.
  - Stimulus: mult with E_req=1.
  - Response: E_busy stays 0; HI/LO unchanged.
  - Stimulus: E_req asserted at cycle 3 of a busy mult.
  - Response: the mult still commits at cycle 5.
- Move and ignore-while-busy:
  - Stimulus: mthi A=0xCAFEBABE.
  - Response: HI=0xCAFEBABE the next cycle; E_busy=0.
  - Stimulus: E_start with mult asserted while busy.
  - Response: ignored; only the original result commits.
- Reset mid-operation:
  - Stimulus: reset asserted asynchronously (between edges) at cycle 3 of a div.
  - Response: E_busy=0, HI=LO=0 immediately; no commit after release.
  - Stimulus: a new mult after reset release.
  - Response: normal operation.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared MDU op encodings and latency defaults.
// Imported by decode control and the execute-stage MDU.
package e_mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational multiply/divide datapath.
// Signed ops are done on magnitudes, then the sign is restored.
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] i_op,
  input  logic [31:0]         i_a,
  input  logic [31:0]         i_b,
  output logic [31:0]         o_hi,
  output logic [31:0]         o_lo,
  output logic                o_dbz
);

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_ua;
  logic [31:0] w_ub;
  logic [31:0] w_ub_nz;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_is_mul = (i_op == MDU_MULT) || (i_op == MDU_MULTU);
  assign w_is_div = (i_op == MDU_DIV) || (i_op == MDU_DIVU);
  assign w_sgn    = (i_op == MDU_MULT) || (i_op == MDU_DIV);

  assign w_a_neg = w_sgn & i_a[31];
  assign w_b_neg = w_sgn & i_b[31];
  assign w_ua    = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_ub    = w_b_neg ? (32'd0 - i_b) : i_b;

  assign w_prod_u = {32'd0, w_ua} * {32'd0, w_ub};
  assign w_prod   = (w_a_neg ^ w_b_neg) ? (64'd0 - w_prod_u) : w_prod_u;

  // Divisor forced to 1 on zero so the datapath stays defined.
  assign w_ub_nz = (w_ub == 32'd0) ? 32'd1 : w_ub;
  assign w_q_u   = w_ua / w_ub_nz;
  assign w_r_u   = w_ua % w_ub_nz;
  assign w_q     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_u) : w_q_u;
  assign w_r     = w_a_neg ? (32'd0 - w_r_u) : w_r_u;

  // Select product or quotient/remainder by op class.
  always_comb begin
    o_hi  = 32'd0;
    o_lo  = 32'd0;
    o_dbz = 1'b0;
    unique case (1'b1)
      w_is_mul: begin
        o_hi = w_prod[63:32];
        o_lo = w_prod[31:0];
      end
      w_is_div: begin
        o_hi  = w_r;
        o_lo  = w_q;
        o_dbz = (i_b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: execute-stage MDU owning HI/LO.
// Results are held in temp regs and committed when the count expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                E_start,
  input  logic [MDU_OP_W-1:0] E_mdu_op,
  input  logic [31:0]         E_A,
  input  logic [31:0]         E_B,
  input  logic                E_req,
  output logic                E_busy,
  output logic [31:0]         E_HI,
  output logic [31:0]         E_LO,
  output logic [31:0]         E_mdu_out
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_thi;
  logic [31:0]      r_tlo;
  logic             r_nocommit;

  logic        w_busy;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic        w_dbz;

  mdu_calc u_calc (
    .i_op  (E_mdu_op),
    .i_a   (E_A),
    .i_b   (E_B),
    .o_hi  (w_hi),
    .o_lo  (w_lo),
    .o_dbz (w_dbz)
  );

  assign w_busy   = (r_cnt != '0);
  assign w_accept = E_start & ~E_req & ~w_busy;
  assign w_is_mul = (E_mdu_op == MDU_MULT) || (E_mdu_op == MDU_MULTU);
  assign w_is_div = (E_mdu_op == MDU_DIV) || (E_mdu_op == MDU_DIVU);

  // Count down in-flight ops and commit; otherwise accept a new op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_thi      <= 32'd0;
      r_tlo      <= 32'd0;
      r_nocommit <= 1'b0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1) && !r_nocommit) begin
        r_hi <= r_thi;
        r_lo <= r_tlo;
      end
    end else if (w_accept) begin
      unique case (1'b1)
        w_is_mul: begin
          r_thi      <= w_hi;
          r_tlo      <= w_lo;
          r_nocommit <= 1'b0;
          r_cnt      <= CNT_W'(MULT_CYCLES);
        end
        w_is_div: begin
          r_thi      <= w_hi;
          r_tlo      <= w_lo;
          r_nocommit <= w_dbz;
          r_cnt      <= CNT_W'(DIV_CYCLES);
        end
        (E_mdu_op == MDU_MTHI): r_hi <= E_A;
        (E_mdu_op == MDU_MTLO): r_lo <= E_A;
        default: ;
      endcase
    end
  end

  assign E_busy = w_busy;
  assign E_HI   = r_hi;
  assign E_LO   = r_lo;

  // Move-from reads are purely combinational.
  always_comb begin
    E_mdu_out = 32'd0;
    if (E_mdu_op == MDU_MFHI) E_mdu_out = r_hi;
    else if (E_mdu_op == MDU_MFLO) E_mdu_out = r_lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu.
// Inputs change #1 after posedge; outputs sampled there too.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_req;
  logic        E_busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_mdu_out;

  int n_cmp = 0;
  int n_bad = 0;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .E_start   (E_start),
    .E_mdu_op  (E_mdu_op),
    .E_A       (E_A),
    .E_B       (E_B),
    .E_req     (E_req),
    .E_busy    (E_busy),
    .E_HI      (E_HI),
    .E_LO      (E_LO),
    .E_mdu_out (E_mdu_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one edge, then drop start/req.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic req);
    E_start  = 1'b1;
    E_mdu_op = op;
    E_A      = a;
    E_B      = b;
    E_req    = req;
    tick();
    E_start  = 1'b0;
    E_mdu_op = 4'd0;
    E_req    = 1'b0;
  endtask

  // Count sampled busy cycles, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (E_busy && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    E_start  = 1'b0;
    E_mdu_op = 4'd0;
    E_A      = 32'd0;
    E_B      = 32'd0;
    E_req    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (E_busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy got %0b want 0", E_busy);
    end
    n_cmp++;
    if (E_HI !== 32'd0) begin
      n_bad++; $display("FAIL rst_hi got %h want 0", E_HI);
    end
    n_cmp++;
    if (E_LO !== 32'd0) begin
      n_bad++; $display("FAIL rst_lo got %h want 0", E_LO);
    end
  endtask

  task automatic test_mult_signed();
    int n;
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    wait_idle(n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++; $display("FAIL mult_busy got %0d want 5", n);
    end
    n_cmp++;
    if (E_HI !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL mult_hi got %h want ffffffff", E_HI);
    end
    n_cmp++;
    if (E_LO !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL mult_lo got %h want fffffffe", E_LO);
    end
    E_mdu_op = MDU_MFHI;
    #1;
    n_cmp++;
    if (E_mdu_out !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL mfhi got %h want ffffffff", E_mdu_out);
    end
    E_mdu_op = MDU_MFLO;
    #1;
    n_cmp++;
    if (E_mdu_out !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL mflo got %h want fffffffe", E_mdu_out);
    end
    E_mdu_op = MDU_NONE;
    #1;
    n_cmp++;
    if (E_mdu_out !== 32'd0) begin
      n_bad++; $display("FAIL mdu_out_none got %h want 0", E_mdu_out);
    end
  endtask

  task automatic test_mult_unsigned();
    int n;
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    wait_idle(n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++; $display("FAIL multu_busy got %0d want 5", n);
    end
    n_cmp++;
    if (E_HI !== 32'h0000_0001) begin
      n_bad++; $display("FAIL multu_hi got %h want 00000001", E_HI);
    end
    n_cmp++;
    if (E_LO !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL multu_lo got %h want fffffffe", E_LO);
    end
  endtask

  task automatic test_div();
    int n;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_idle(n);
    n_cmp++;
    if (n !== 10) begin
      n_bad++; $display("FAIL div_busy got %0d want 10", n);
    end
    n_cmp++;
    if (E_LO !== 32'hFFFF_FFFD) begin
      n_bad++; $display("FAIL div_lo got %h want fffffffd", E_LO);
    end
    n_cmp++;
    if (E_HI !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL div_hi got %h want ffffffff", E_HI);
    end
    issue(MDU_DIVU, 32'h0000_0064, 32'h0000_0000, 1'b0);
    wait_idle(n);
    n_cmp++;
    if (n !== 10) begin
      n_bad++; $display("FAIL div0_busy got %0d want 10", n);
    end
    n_cmp++;
    if (E_LO !== 32'hFFFF_FFFD || E_HI !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL div0_keep got %h/%h want ffffffff/fffffffd", E_HI, E_LO);
    end
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    n_cmp++;
    if (E_LO !== 32'h8000_0000 || E_HI !== 32'd0) begin
      n_bad++;
      $display("FAIL div_ovf got %h/%h want 00000000/80000000", E_HI, E_LO);
    end
    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_idle(n);
    n_cmp++;
    if (E_LO !== 32'h7FFF_FFFC || E_HI !== 32'h0000_0001) begin
      n_bad++;
      $display("FAIL divu got %h/%h want 00000001/7ffffffc", E_HI, E_LO);
    end
  endtask

  task automatic test_flush();
    int n;
    issue(MDU_MTLO, 32'h1234_5678, 32'd0, 1'b1);
    n_cmp++;
    if (E_LO !== 32'h7FFF_FFFC) begin
      n_bad++; $display("FAIL flush_mtlo got %h want 7ffffffc", E_LO);
    end
    issue(MDU_MULT, 32'h0000_0003, 32'h0000_0004, 1'b1);
    n_cmp++;
    if (E_busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_mult_busy got %0b want 0", E_busy);
    end
    tick();
    tick();
    n_cmp++;
    if (E_LO !== 32'h7FFF_FFFC || E_HI !== 32'h0000_0001) begin
      n_bad++;
      $display("FAIL flush_mult_keep got %h/%h want 00000001/7ffffffc",
               E_HI, E_LO);
    end
    issue(MDU_MULT, 32'h0000_0003, 32'h0000_0004, 1'b0);
    n = 0;
    while (E_busy && n < 50) begin
      E_req = (n == 2);
      n++;
      tick();
    end
    E_req = 1'b0;
    n_cmp++;
    if (n !== 5) begin
      n_bad++; $display("FAIL req_mid_busy got %0d want 5", n);
    end
    n_cmp++;
    if (E_LO !== 32'h0000_000C || E_HI !== 32'd0) begin
      n_bad++;
      $display("FAIL req_mid_res got %h/%h want 00000000/0000000c", E_HI, E_LO);
    end
  endtask

  task automatic test_move_ignore();
    int n;
    issue(MDU_MTHI, 32'hCAFE_BABE, 32'd0, 1'b0);
    n_cmp++;
    if (E_HI !== 32'hCAFE_BABE) begin
      n_bad++; $display("FAIL mthi got %h want cafebabe", E_HI);
    end
    n_cmp++;
    if (E_busy !== 1'b0) begin
      n_bad++; $display("FAIL mthi_busy got %0b want 0", E_busy);
    end
    issue(MDU_MTLO, 32'h1234_5678, 32'd0, 1'b0);
    n_cmp++;
    if (E_LO !== 32'h1234_5678 || E_HI !== 32'hCAFE_BABE) begin
      n_bad++;
      $display("FAIL mtlo got %h/%h want cafebabe/12345678", E_HI, E_LO);
    end
    issue(MDU_MULT, 32'h0000_0002, 32'h0000_0003, 1'b0);
    n = 0;
    while (E_busy && n < 50) begin
      E_start  = (n == 1);
      E_mdu_op = (n == 1) ? MDU_MULT : MDU_NONE;
      E_A      = 32'h0000_0007;
      E_B      = 32'h0000_0007;
      n++;
      tick();
    end
    E_start  = 1'b0;
    E_mdu_op = 4'd0;
    n_cmp++;
    if (n !== 5) begin
      n_bad++; $display("FAIL ignore_busy got %0d want 5", n);
    end
    n_cmp++;
    if (E_LO !== 32'h0000_0006 || E_HI !== 32'd0) begin
      n_bad++;
      $display("FAIL ignore_res got %h/%h want 00000000/00000006", E_HI, E_LO);
    end
    tick();
    n_cmp++;
    if (E_busy !== 1'b0 || E_LO !== 32'h0000_0006) begin
      n_bad++;
      $display("FAIL ignore_after got %0b/%h want 0/00000006", E_busy, E_LO);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(MDU_MTHI, 32'hCAFE_BABE, 32'd0, 1'b0);
    issue(MDU_DIV, 32'h0000_0064, 32'h0000_0007, 1'b0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (E_busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid got %0b/%h/%h want 0/0/0", E_busy, E_HI, E_LO);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (E_busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_nocommit got %0b/%h/%h want 0/0/0",
               E_busy, E_HI, E_LO);
    end
    issue(MDU_MULT, 32'h0000_0005, 32'h0000_0006, 1'b0);
    wait_idle(n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++; $display("FAIL rst_after_busy got %0d want 5", n);
    end
    n_cmp++;
    if (E_LO !== 32'h0000_001E || E_HI !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_after_res got %h/%h want 00000000/0000001e",
               E_HI, E_LO);
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_mult_unsigned();
    test_div();
    test_flush();
    test_move_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
